serial_subtractor: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/serial_subtractor_full_subtractor.sv | 43 ++++
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial subtractor FSM states and result flags.
package alu_pkg;

  typedef enum logic [1:0] {
    SS_IDLE,
    SS_RUN,
    SS_DONE
  } ss_state_t;

  typedef struct packed {
    logic zero;
    logic negative;
    logic overflow;
    logic borrow;
  } alu_flags_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor from two half-subtractor cells and an OR,
// the subtract-direction twin of the full adder.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b;
  assign bout = ~a & b;

endmodule

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs0 (
    .a    (a),
    .b    (b),
    .diff (d1),
    .bout (b1)
  );

  half_subtractor u_hs1 (
    .a    (d1),
    .b    (bin),
    .diff (diff),
    .bout (b2)
  );

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus borrow flop.
// Parallel load via valid/ready, parallel result with flags and done pulse.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ss_state_t state;
  ss_state_t state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nx;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a_msb;
  logic             b_msb;
  logic             d;
  logic             bo;
  logic             accept;
  alu_flags_t       flags;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .diff (d),
    .bout (bo)
  );

  assign res_nx = {d, res_sh[WIDTH-1:1]};
  assign accept = start_valid && start_ready;

  always_comb begin
    state_nx    = state;
    start_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state)
      SS_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nx = SS_RUN;
      end
      SS_RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = SS_DONE;
      end
      SS_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = SS_IDLE;
      end
      default: state_nx = SS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SS_IDLE;
    else        state <= state_nx;
  end

  // Flags are registered alongside the result so they hold between ops
  // and read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      flags  <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      br    <= 1'b0;
      cnt   <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == SS_RUN) begin
      res_sh <= res_nx;
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      br     <= bo;
      if (cnt != LAST) cnt <= cnt + 1'b1;
      flags.zero     <= (res_nx == '0);
      flags.negative <= res_nx[WIDTH-1];
      flags.overflow <= (a_msb != b_msb) && (res_nx[WIDTH-1] != a_msb);
      flags.borrow   <= bo;
    end
  end

  assign diff     = res_sh;
  assign borrow   = flags.borrow;
  assign zero     = flags.zero;
  assign negative = flags.negative;
  assign overflow = flags.overflow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic
// reference model; directed cases, corner sweep and random operands.
module tb_serial_subtractor;

  localparam int W = 16;
  localparam int P = W + 2;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;
  logic         negative;
  logic         overflow;
  logic         busy;
  logic         done;

  int n_cmp;
  int n_bad;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .diff        (diff),
    .borrow      (borrow),
    .zero        (zero),
    .negative    (negative),
    .overflow    (overflow),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sval(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction

  task automatic check_result(input string tag,
                              input logic [W-1:0] oa,
                              input logic [W-1:0] ob);
    int sd;
    logic [W-1:0] ed;
    ed = W'((int'(oa) - int'(ob)) & ((1 << W) - 1));
    sd = sval(oa) - sval(ob);
    chk({tag, ".diff"}, 32'(diff), 32'(ed));
    chk({tag, ".borrow"}, 32'(borrow), 32'(oa < ob));
    chk({tag, ".zero"}, 32'(zero), 32'(ed == 0));
    chk({tag, ".neg"}, 32'(negative), 32'(ed[W-1]));
    chk({tag, ".ovf"}, 32'(overflow),
        32'(sd > (1 << (W-1)) - 1 || sd < -(1 << (W-1))));
  endtask

  // Starts from a negedge with the block idle; ends at the negedge after
  // the post-DONE edge, idle again.
  task automatic do_op(input string tag,
                       input logic [W-1:0] oa,
                       input logic [W-1:0] ob);
    int k;
    a = oa;
    b = ob;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    chk({tag, ".rdy_drop"}, 32'(start_ready), 32'd0);
    k = 0;
    while (!done && k < 3 * W) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    chk({tag, ".latency"}, 32'(k), 32'(W));
    check_result(tag, oa, ob);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".done_1cyc"}, 32'(done), 32'd0);
    chk({tag, ".rdy_back"}, 32'(start_ready), 32'd1);
  endtask

  logic [W-1:0] corners [5];
  logic [W-1:0] qa [$];
  logic [W-1:0] qb [$];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    corners[0] = 16'h0000;
    corners[1] = 16'h0001;
    corners[2] = 16'h7FFF;
    corners[3] = 16'h8000;
    corners[4] = 16'hFFFF;
    rst_n = 1'b0;
    start_valid = 1'b0;
    a = '0;
    b = '0;
    #12;
    chk("rst.ready", 32'(start_ready), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.diff", 32'(diff), 32'd0);
    chk("rst.flags", {28'd0, zero, negative, overflow, borrow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("d5m3", 16'd5, 16'd3);
    do_op("d3m5", 16'd3, 16'd5);
    do_op("eq", 16'h1234, 16'h1234);
    do_op("ovf1", 16'h8000, 16'h0001);
    do_op("ovf2", 16'h7FFF, 16'hFFFF);

    // start_valid held high, fresh operands each cycle
    start_valid = 1'b1;
    for (int e = 0; e < 3 * P; e++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (e % P == 0) begin
        qa.push_back(a);
        qb.push_back(b);
      end
      @(posedge clk);
      @(negedge clk);
      chk("stream.ready", 32'(start_ready), 32'(e % P == P - 1));
      chk("stream.done", 32'(done), 32'(e % P == W));
      if (e % P == W && qa.size() > 0)
        check_result("stream", qa.pop_front(), qb.pop_front());
    end
    start_valid = 1'b0;
    // Pipeline may have accepted at the final edge; drain it.
    for (int i = 0; i < P && !start_ready; i++) @(negedge clk);
    chk("stream.idle", 32'(start_ready), 32'd1);

    // Async reset during RUN bit 7
    a = 16'h4321;
    b = 16'h0123;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.ready", 32'(start_ready), 32'd1);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.diff", 32'(diff), 32'd0);
    chk("arst.flags", {28'd0, zero, negative, overflow, borrow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      chk("arst.nodone", 32'(done), 32'd0);
    end
    do_op("after_rst", 16'd100, 16'd1);

    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        do_op($sformatf("corner%0d%0d", i, j), corners[i], corners[j]);

    for (int i = 0; i < 12; i++)
      do_op($sformatf("rand%0d", i), W'($urandom), W'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
